ieu_arb: RTL and testbench
==========================

IEU_ARB -- requirements
Module: ieu_arb

Interface
REQ-001 Parameter N, default 16, immediate input width.
REQ-002 Parameter M, default 32, extended output width; M > N.
REQ-003 Port clk  in  1  rising-edge clock.
REQ-004 Port rst  in  1  asynchronous reset, active-high.
REQ-005 Port r0_valid  in  1  requester 0 has an immediate to extend.
REQ-006 Port r0_ready  out  1  requester 0 transfer accepted this cycle.
REQ-007 Port r0_u  in  1  requester 0 extension mode: 1 = zero-extend, 0 = sign-extend.
REQ-008 Port r0_imm  in  N  requester 0 immediate.
REQ-009 Ports r1_valid, r1_ready, r1_u, r1_imm SHALL match REQ-005..008 for requester 1.
REQ-010 Port resp_valid  out  1  extended result available.
REQ-011 Port resp_ready  in  1  consumer accepts result.
REQ-012 Port resp_id  out  1  requester index that owns resp_data.
REQ-013 Port resp_data  out  M  extended immediate.

Function
REQ-014 Two-state FSM: IDLE (no result held), HOLD (result held, resp_valid=1).
REQ-015 Grant condition: (state==IDLE or resp_ready==1) and the requester wins arbitration; the winner's rX_ready SHALL be 1 combinationally in that cycle, and the loser's SHALL be 0.
REQ-016 Arbitration SHALL be round-robin: with one valid requester, that requester wins; with both valid, the requester not granted last wins.
REQ-017 The last-grant pointer SHALL update only on an accepted transfer (valid and ready both 1).
REQ-018 On an accepted transfer, resp_data SHALL register imm zero-extended (u=1) or sign-extended from bit N-1 (u=0) to M bits, resp_id SHALL register the winner, and the FSM SHALL enter or stay in HOLD; latency is 1 cycle.
REQ-019 In HOLD with resp_ready=1 and no accepted transfer, the FSM SHALL return to IDLE and resp_valid SHALL fall on the next edge.
REQ-020 In HOLD with resp_ready=0, resp_data and resp_id SHALL remain stable and both rX_ready SHALL be 0.
REQ-021 Sustained throughput SHALL be one result per cycle while resp_ready=1.
REQ-022 Requests with valid=0 SHALL never be granted, and a valid request SHALL wait at most one grant behind the other requester.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, resp_valid=0, resp_id=0, resp_data=0, and last-grant=1 so that requester 0 wins the first tie.
REQ-024 Reset during HOLD SHALL discard the held result without asserting any ready.

Configuration
REQ-025 Macro IEU_ARB_STATS_EN defined: adds output ports grant_cnt0 and grant_cnt1, each 16 bits, counting accepted transfers per requester; both reset to 0 and saturate at 0xFFFF.
REQ-026 Macro IEU_ARB_STATS_EN undefined: those ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-027 Shared package ieu_pkg SHALL hold the FSM state encoding (IDLE, HOLD), the default N/M constants, and the extension-mode encoding constants (U_ZERO=1, U_SIGN=0).
REQ-028 Round-robin selection SHALL be a sub-module ieu_rr_pick (inputs: two valids, last-grant; outputs: grant vector).
REQ-029 Extension logic SHALL be inline in ieu_arb.

Verification
REQ-030 Single request: r0_valid=1, r0_u=0, r0_imm=16'hFFF7, resp_ready=1 -> r0_ready=1 same cycle; next cycle resp_valid=1, resp_id=0, resp_data=32'hFFFFFFF7.
REQ-031 Zero-extend: r1_u=1, r1_imm=16'h800B -> resp_data=32'h0000800B, resp_id=1.
REQ-032 Contention: both valid for 4 cycles after reset, resp_ready=1 -> grants in the order 0,1,0,1; one result per cycle.
REQ-033 Backpressure: result held, resp_ready=0 for 3 cycles while r0_valid=1 -> r0_ready=0 and resp_data stable; resp_ready=1 -> r0 is accepted in the same cycle.
REQ-034 Reset in HOLD: assert rst mid-cycle -> resp_valid=0 before the next edge; after release, a tie grants requester 0.
REQ-035 With IEU_ARB_STATS_EN defined: 5 grants to r0 and 3 grants to r1 -> grant_cnt0=5, grant_cnt1=3; force 0xFFFF -> the count stays at 0xFFFF.

Source files
------------

// File: rtl/ieu_pkg.sv
// ----------------------------------------------------------------------------
// ieu_pkg
// Shared definitions for the immediate-extension arbiter:
//   - state_t : two-state response FSM encoding (IDLE, HOLD)
//   - N_DEF / M_DEF : default immediate width and extended width
//   - U_ZERO / U_SIGN : encoding of the per-request extension-mode bit
// ----------------------------------------------------------------------------
package ieu_pkg;

    localparam int N_DEF = 16;
    localparam int M_DEF = 32;

    localparam logic U_ZERO = 1'b1;
    localparam logic U_SIGN = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/ieu_rr_pick.sv
// ----------------------------------------------------------------------------
// ieu_rr_pick
// Two-way round-robin selector.
// Ports:
//   valid0, valid1 : request present from requester 0 / 1
//   last           : index of the requester granted on the last accepted transfer
//   grant[1:0]     : one-hot winner (all zero when nobody is requesting)
// A lone requester always wins; on a tie the requester not granted last wins.
// ----------------------------------------------------------------------------
module ieu_rr_pick (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = {valid1, valid0};
        end
    end

endmodule

// File: rtl/ieu_arb.sv
// ----------------------------------------------------------------------------
// ieu_arb
// Arbitrates two requesters that each supply an N-bit immediate, extends the
// winner's immediate to M bits (zero- or sign-extend per request) and holds
// it in a one-entry response register with valid/ready handshake.
//
// Ports:
//   clk, rst                     : rising-edge clock, async active-high reset
//   rX_valid / rX_ready          : request handshake for requester X (0, 1)
//   rX_u                         : 1 = zero-extend, 0 = sign-extend
//   rX_imm[N-1:0]                : immediate from requester X
//   resp_valid / resp_ready      : response handshake
//   resp_id                      : requester that owns resp_data
//   resp_data[M-1:0]             : extended immediate
//   grant_cnt0/1[15:0]           : saturating accepted-transfer counters,
//                                  present only when IEU_ARB_STATS_EN is defined
//
// Optional feature macro: IEU_ARB_STATS_EN
// ----------------------------------------------------------------------------
module ieu_arb
    import ieu_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic         r0_u,
    input  logic [N-1:0] r0_imm,
    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic         r1_u,
    input  logic [N-1:0] r1_imm,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [M-1:0] resp_data
`ifdef IEU_ARB_STATS_EN
    ,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1
`endif
);

    function automatic logic [M-1:0] extend(input logic u, input logic [N-1:0] imm);
        if (u == U_ZERO) begin
            return {{(M-N){1'b0}}, imm};
        end
        return {{(M-N){imm[N-1]}}, imm};
    endfunction

    state_t       state;
    state_t       state_next;
    logic         last;
    logic [1:0]   grant;
    logic         can_accept;
    logic         accept;
    logic         win_id;
    logic         win_u;
    logic [N-1:0] win_imm;

    ieu_rr_pick u_pick (
        .valid0 (r0_valid),
        .valid1 (r1_valid),
        .last   (last),
        .grant  (grant)
    );

    // The response slot is free when empty or being drained this cycle.
    // Readies are suppressed during reset so a held result is discarded
    // without a new transfer sneaking in.
    assign can_accept = ((state == IDLE) || resp_ready) && !rst;
    assign r0_ready   = can_accept && grant[0];
    assign r1_ready   = can_accept && grant[1];
    assign accept     = r0_ready || r1_ready;

    assign win_id     = grant[1];
    assign win_u      = win_id ? r1_u   : r0_u;
    assign win_imm    = win_id ? r1_imm : r0_imm;

    assign resp_valid = (state == HOLD);

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = HOLD;
        end else if ((state == HOLD) && resp_ready) begin
            state_next = IDLE;
        end
    end

    // last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            resp_id   <= 1'b0;
            resp_data <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                last      <= win_id;
                resp_id   <= win_id;
                resp_data <= extend(win_u, win_imm);
            end
        end
    end

`ifdef IEU_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (r0_ready && (grant_cnt0 != 16'hFFFF)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (r1_ready && (grant_cnt1 != 16'hFFFF)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ieu_arb.sv
// ----------------------------------------------------------------------------
// tb_ieu_arb
// Self-checking bench for ieu_arb: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
// Optional feature macro: IEU_ARB_STATS_EN (enables the counter scenario).
// ----------------------------------------------------------------------------
module tb_ieu_arb;

    localparam int N = 16;
    localparam int M = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         r0_valid = 1'b0;
    logic         r0_ready;
    logic         r0_u = 1'b0;
    logic [N-1:0] r0_imm = '0;
    logic         r1_valid = 1'b0;
    logic         r1_ready;
    logic         r1_u = 1'b0;
    logic [N-1:0] r1_imm = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic         resp_id;
    logic [M-1:0] resp_data;
`ifdef IEU_ARB_STATS_EN
    logic [15:0]  grant_cnt0;
    logic [15:0]  grant_cnt1;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ieu_arb #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .r0_valid   (r0_valid),
        .r0_ready   (r0_ready),
        .r0_u       (r0_u),
        .r0_imm     (r0_imm),
        .r1_valid   (r1_valid),
        .r1_ready   (r1_ready),
        .r1_u       (r1_u),
        .r1_imm     (r1_imm),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
`ifdef IEU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    // Reference extension: value of the immediate as an integer, reduced
    // modulo 2^32 (negative values wrap).
    function automatic logic [M-1:0] ref_ext(input logic u, input logic [N-1:0] imm);
        longint v;
        v = longint'(imm);
        if (!u && (imm >= 16'h8000)) v = v - 65536;
        return v[M-1:0];
    endfunction

    task automatic idle_inputs();
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_u = 1'b0; r1_u = 1'b0;
        r0_imm = '0; r1_imm = '0;
        resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_data !== '0) begin
            fails++;
            $display("FAIL reset_state: valid=%b id=%b data=%h required 0/0/0", resp_valid, resp_id, resp_data);
        end
        checks++;
        if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: r0_ready=%b r1_ready=%b required 0/0", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        r0_valid = 1'b1; r0_u = 1'b0; r0_imm = 16'hFFF7; resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_grant: r0_ready=%b r1_ready=%b resp_valid=%b required 1/0/0", r0_ready, r1_ready, resp_valid);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'hFFFFFFF7) begin
            fails++;
            $display("FAIL single_resp: valid=%b id=%b data=%h required 1/0/fffffff7", resp_valid, resp_id, resp_data);
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drain: resp_valid=%b required 0", resp_valid);
        end
    endtask

    task automatic test_zero_ext();
        r1_valid = 1'b1; r1_u = 1'b1; r1_imm = 16'h800B; resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
            fails++;
            $display("FAIL zext_grant: r0_ready=%b r1_ready=%b required 0/1", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        r1_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_data !== 32'h0000800B) begin
            fails++;
            $display("FAIL zext_resp: valid=%b id=%b data=%h required 1/1/0000800b", resp_valid, resp_id, resp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        logic [M-1:0] exp_data;
        do_reset();
        r0_valid = 1'b1; r0_u = 1'b1; r0_imm = 16'h0011;
        r1_valid = 1'b1; r1_u = 1'b0; r1_imm = 16'h8022;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (r0_ready !== ((i % 2) == 0) || r1_ready !== ((i % 2) == 1)) begin
                fails++;
                $display("FAIL contention_grant[%0d]: r0_ready=%b r1_ready=%b required %b/%b", i, r0_ready, r1_ready, (i % 2) == 0, (i % 2) == 1);
            end
            @(posedge clk); #1;
            exp_data = ((i % 2) == 0) ? 32'h00000011 : 32'hFFFF8022;
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== 1'(i % 2) || resp_data !== exp_data) begin
                fails++;
                $display("FAIL contention_resp[%0d]: valid=%b id=%b data=%h required 1/%0d/%h", i, resp_valid, resp_id, resp_data, i % 2, exp_data);
            end
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        r1_valid = 1'b1; r1_u = 1'b1; r1_imm = 16'h00AB; resp_ready = 1'b1;
        @(posedge clk); #1;
        r1_valid = 1'b0; resp_ready = 1'b0;
        r0_valid = 1'b1; r0_u = 1'b0; r0_imm = 16'h8001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (r0_ready !== 1'b0 || r1_ready !== 1'b0 || resp_valid !== 1'b1 ||
                resp_id !== 1'b1 || resp_data !== 32'h000000AB) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: r0_ready=%b valid=%b id=%b data=%h required 0/1/1/000000ab", i, r0_ready, resp_valid, resp_id, resp_data);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (r0_ready !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release: r0_ready=%b required 1", r0_ready);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'hFFFF8001) begin
            fails++;
            $display("FAIL backpressure_resp: valid=%b id=%b data=%h required 1/0/ffff8001", resp_valid, resp_id, resp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_hold();
        r0_valid = 1'b1; r0_u = 1'b1; r0_imm = 16'h0055; resp_ready = 1'b0;
        @(posedge clk); #1;
        r1_valid = 1'b1; r1_u = 1'b1; r1_imm = 16'h0066;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h00000055) begin
            fails++;
            $display("FAIL rsthold_pre: valid=%b data=%h required 1/00000055", resp_valid, resp_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_data !== '0 ||
            r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
            fails++;
            $display("FAIL rsthold_async: valid=%b id=%b data=%h r0_ready=%b r1_ready=%b required all 0", resp_valid, resp_id, resp_data, r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            fails++;
            $display("FAIL rsthold_tie: r0_ready=%b r1_ready=%b required 1/0", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'h00000055) begin
            fails++;
            $display("FAIL rsthold_resp: valid=%b id=%b data=%h required 1/0/00000055", resp_valid, resp_id, resp_data);
        end
        @(posedge clk); #1;
    endtask

    // Transaction-level model: a single result slot plus "who was served
    // last"; a tie goes to whoever was not served last.
    task automatic test_random();
        logic         m_full;
        int           m_prev;
        logic         m_id;
        logic [M-1:0] m_data;
        int           winner;
        int           wait0, wait1;
        do_reset();
        m_full = 1'b0; m_prev = 1; m_id = 1'b0; m_data = '0;
        wait0 = 0; wait1 = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            r0_valid   = ($urandom_range(0, 3) != 0);
            r1_valid   = ($urandom_range(0, 3) != 0);
            r0_u       = $urandom_range(0, 1);
            r1_u       = $urandom_range(0, 1);
            r0_imm     = ($urandom_range(0, 7) == 0) ? 16'h8000 : N'($urandom);
            r1_imm     = ($urandom_range(0, 7) == 0) ? 16'h7FFF : N'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            winner = -1;
            if (!m_full || resp_ready) begin
                if (r0_valid && r1_valid) winner = 1 - m_prev;
                else if (r0_valid)        winner = 0;
                else if (r1_valid)        winner = 1;
            end
            checks++;
            if (r0_ready !== (winner == 0) || r1_ready !== (winner == 1)) begin
                fails++;
                $display("FAIL random_grant[%0d]: r0_ready=%b r1_ready=%b required winner %0d", cyc, r0_ready, r1_ready, winner);
            end
            checks++;
            if (resp_valid !== m_full || (m_full && (resp_id !== m_id || resp_data !== m_data))) begin
                fails++;
                $display("FAIL random_resp[%0d]: valid=%b id=%b data=%h required %b/%b/%h", cyc, resp_valid, resp_id, resp_data, m_full, m_id, m_data);
            end
            // A requester may be passed over at most once while it waits
            // behind the other one in an open slot.
            if (winner == 1 && r0_valid) wait0++; else if (winner == 0 || !r0_valid) wait0 = 0;
            if (winner == 0 && r1_valid) wait1++; else if (winner == 1 || !r1_valid) wait1 = 0;
            checks++;
            if (wait0 > 1 || wait1 > 1) begin
                fails++;
                $display("FAIL random_fair[%0d]: skipped r0=%0d r1=%0d required <=1", cyc, wait0, wait1);
            end
            @(posedge clk);
            if (winner >= 0) begin
                m_full = 1'b1;
                m_prev = winner;
                m_id   = 1'(winner);
                m_data = (winner == 0) ? ref_ext(r0_u, r0_imm) : ref_ext(r1_u, r1_imm);
            end else if (resp_ready) begin
                m_full = 1'b0;
            end
            #1;
        end
        idle_inputs();
        resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef IEU_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        resp_ready = 1'b1;
        r0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        r0_valid = 1'b0; r1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        r1_valid = 1'b0;
        checks++;
        if (grant_cnt0 !== 16'd5 || grant_cnt1 !== 16'd3) begin
            fails++;
            $display("FAIL stats_count: cnt0=%0d cnt1=%0d required 5/3", grant_cnt0, grant_cnt1);
        end
        force dut.grant_cnt0 = 16'hFFFF;
        #1;
        release dut.grant_cnt0;
        r0_valid = 1'b1;
        @(posedge clk); #1;
        r0_valid = 1'b0;
        checks++;
        if (grant_cnt0 !== 16'hFFFF) begin
            fails++;
            $display("FAIL stats_saturate: cnt0=%h required ffff", grant_cnt0);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_zero_ext();
        test_contention();
        test_backpressure();
        test_reset_hold();
        test_random();
`ifdef IEU_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
